// File: rtl/twi_pkg.sv
// Shared definitions for the TWI slave endpoint: FSM states, frame bit
// positions and bus-level ACK/NACK values.
package twi_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK
    } twi_state_e;

    localparam int   RW_BIT    = 0;
    localparam logic ACK       = 1'b0;
    localparam logic NACK      = 1'b1;
    localparam int   RD_STAGES = 1;

    function automatic logic addr_hit(input logic [7:0] frame, input logic [6:0] addr);
        return frame[7:1] == addr;
    endfunction

endpackage

// File: rtl/twi_in_filter.sv
// Bus line conditioner: 2-FF synchroniser, run-length glitch filter and
// one-cycle rise/fall flags aligned with the filtered level change.
module twi_in_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    // Idle bus is high, so everything resets to the released level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            lvl_o  <= 1'b1;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pin_i};
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            if (sync_q[1] == lvl_o) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                cnt_q  <= '0;
                lvl_o  <= sync_q[1];
                rise_o <= sync_q[1];
                fall_o <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/twi_slave_regs.sv
// TWI slave endpoint: address match, byte pointer, and a synchronous
// register read/write port driven from the bus transfers.
module twi_slave_regs
    import twi_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h3C,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    inout  wire        sda_io,
    output logic [7:0] reg_addr_o,
    output logic       reg_wr_o,
    output logic [7:0] reg_dat_o,
    output logic       reg_rd_o,
    input  logic [7:0] reg_dat_i,
    output logic       busy_o,
    output logic       stop_o
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;
    logic start_ev, stop_ev;

    twi_state_e state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d, ptr_q, ptr_d;
    logic [7:0] addr_q, addr_d, wdat_q, wdat_d;
    logic       rw_q, rw_d, oe_q, oe_d, mack_q, mack_d, busy_q, busy_d;
    logic       wr_q, wr_d, stop_q, stop_d, rd_d;
    logic [RD_STAGES:0] vld_pipe;
    logic [7:0] byte_in;

    twi_in_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
        .clk_i(clk_i), .rst_ni(rst_ni), .pin_i(scl_i),
        .lvl_o(scl_f), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    twi_in_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
        .clk_i(clk_i), .rst_ni(rst_ni), .pin_i(sda_io),
        .lvl_o(sda_f), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    assign start_ev = sda_fall & scl_f;
    assign stop_ev  = sda_rise & scl_f;
    assign byte_in  = {shift_q[6:0], sda_f};

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        rw_d    = rw_q;
        oe_d    = oe_q;
        mack_d  = mack_q;
        busy_d  = busy_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        stop_d  = 1'b0;

        case (state_q)
            S_ADDR, S_PTR, S_WDATA: begin
                if (scl_rise) begin
                    shift_d = byte_in;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        if (state_q == S_ADDR) begin
                            if (addr_hit(byte_in, SLAVE_ADDR)) begin
                                state_d = S_ADDR_ACK;
                                rw_d    = byte_in[RW_BIT];
                                busy_d  = 1'b1;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end else if (state_q == S_PTR) begin
                            ptr_d   = byte_in;
                            state_d = S_PTR_ACK;
                        end else begin
                            wr_d    = 1'b1;
                            addr_d  = ptr_q;
                            wdat_d  = byte_in;
                            ptr_d   = ptr_q + 8'd1;
                            state_d = S_WDATA_ACK;
                        end
                    end
                end
            end

            // First fall after the byte drives ACK, the next one releases it.
            S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                if (scl_fall) begin
                    oe_d = ~oe_q;
                    if (oe_q) begin
                        if (state_q == S_ADDR_ACK && rw_q) begin
                            rd_d    = 1'b1;
                            addr_d  = ptr_q;
                            state_d = S_RDATA;
                        end else if (state_q == S_ADDR_ACK) begin
                            state_d = S_PTR;
                        end else begin
                            state_d = S_WDATA;
                        end
                    end
                end
            end

            S_RDATA: begin
                // Read data is consumed straight off the port so the MSB hits
                // the bus in the same cycle the shift register loads.
                if (vld_pipe[RD_STAGES]) begin
                    shift_d = reg_dat_i;
                    oe_d    = ~reg_dat_i[7];
                    ptr_d   = ptr_q + 8'd1;
                end
                if (scl_rise) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_RDATA_ACK;
                end else if (scl_fall) begin
                    shift_d = shift_q << 1;
                    oe_d    = ~shift_q[6];
                end
            end

            S_RDATA_ACK: begin
                if (scl_rise) begin
                    mack_d = (sda_f == ACK);
                    if (sda_f == NACK) state_d = S_IDLE;
                end else if (scl_fall) begin
                    if (mack_q) begin
                        mack_d  = 1'b0;
                        rd_d    = 1'b1;
                        addr_d  = ptr_q;
                        state_d = S_RDATA;
                    end else begin
                        oe_d = 1'b0;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (start_ev) begin
            state_d = S_ADDR;
            bit_d   = '0;
            oe_d    = 1'b0;
            mack_d  = 1'b0;
            busy_d  = 1'b0;
        end else if (stop_ev) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            mack_d  = 1'b0;
            busy_d  = 1'b0;
            stop_d  = busy_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            bit_q    <= '0;
            shift_q  <= '0;
            ptr_q    <= '0;
            addr_q   <= '0;
            wdat_q   <= '0;
            rw_q     <= 1'b0;
            oe_q     <= 1'b0;
            mack_q   <= 1'b0;
            busy_q   <= 1'b0;
            wr_q     <= 1'b0;
            stop_q   <= 1'b0;
            vld_pipe <= '0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            rw_q     <= rw_d;
            oe_q     <= oe_d;
            mack_q   <= mack_d;
            busy_q   <= busy_d;
            wr_q     <= wr_d;
            stop_q   <= stop_d;
            vld_pipe <= {vld_pipe[RD_STAGES-1:0], rd_d};
        end
    end

    assign sda_io     = oe_q ? 1'b0 : 1'bz;
    assign reg_addr_o = addr_q;
    assign reg_wr_o   = wr_q;
    assign reg_dat_o  = wdat_q;
    assign reg_rd_o   = vld_pipe[0];
    assign busy_o     = busy_q;
    assign stop_o     = stop_q;

endmodule

// File: tb/tb_twi_slave_regs.sv
// Bench for twi_slave_regs: bit-level bus master, register-file responder
// and a byte-array reference of what the register space should hold.
module tb_twi_slave_regs;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic       glitch_en = 1'b0;
    wire        sda;
    logic [7:0] reg_addr, reg_wdat, reg_dat_i;
    logic       reg_wr, reg_rd, busy, stop;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    twi_slave_regs #(.SLAVE_ADDR(7'h3C), .FILTER_LEN(3)) dut (
        .clk_i(clk), .rst_ni(rst_n), .scl_i(scl), .sda_io(sda),
        .reg_addr_o(reg_addr), .reg_wr_o(reg_wr), .reg_dat_o(reg_wdat),
        .reg_rd_o(reg_rd), .reg_dat_i(reg_dat_i), .busy_o(busy), .stop_o(stop)
    );

    // Register file seen by the DUT, plus logs of every strobe.
    logic [7:0]  dev_mem [256];
    logic [7:0]  ref_mem [256];
    logic [15:0] wlog [$];
    logic [7:0]  rlog [$];
    int stop_cnt = 0, drv_cnt = 0, proto_err = 0;
    int n_chk = 0, n_err = 0;

    always @(posedge clk) begin
        if (reg_wr) begin
            wlog.push_back({reg_addr, reg_wdat});
            dev_mem[reg_addr] = reg_wdat;
        end
        if (reg_rd) begin
            rlog.push_back(reg_addr);
            reg_dat_i <= dev_mem[reg_addr];
        end
        if (reg_wr && reg_rd) proto_err++;
        if (stop) begin
            stop_cnt++;
            if (busy) proto_err++;
        end
        if (sda === 1'b0 && !m_low) drv_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Entry: SCL low for Q clocks. Exit: SCL fell Q clocks ago.
    task automatic bit_tx(input logic b, output logic r);
        m_low = ~b;
        if (glitch_en) begin
            wait_clk(3); scl = 1'b1; wait_clk(1); scl = 1'b0; wait_clk(Q - 4);
        end else begin
            wait_clk(Q);
        end
        scl = 1'b1;
        wait_clk(2 * Q);
        r = (sda === 1'b0) ? 1'b0 : 1'b1;
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_start;
        m_low = 1'b0; wait_clk(Q);
        scl = 1'b1;   wait_clk(Q);
        m_low = 1'b1; wait_clk(Q);
        scl = 1'b0;   wait_clk(Q);
    endtask

    task automatic i2c_stop;
        m_low = 1'b1; wait_clk(Q);
        scl = 1'b1;   wait_clk(Q);
        m_low = 1'b0; wait_clk(2 * Q);
    endtask

    task automatic byte_tx(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_tx(d[i], r);
        bit_tx(1'b1, ack);
    endtask

    task automatic byte_rx(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_tx(1'b1, r);
            d[i] = r;
        end
        bit_tx(nack, r);
    endtask

    task automatic wr_txn(input logic [7:0] a, input logic [7:0] p, input int n,
                          input logic [3:0][7:0] dat, input logic match);
        logic r;
        int w0 = wlog.size(), s0 = stop_cnt, d0 = drv_cnt;
        i2c_start;
        byte_tx(a, r);
        chk("addr_ack", 32'(r), match ? 32'd0 : 32'd1);
        if (match) begin
            byte_tx(p, r);
            chk("ptr_ack", 32'(r), 0);
            chk("busy_mid", 32'(busy), 1);
            for (int i = 0; i < n; i++) begin
                byte_tx(dat[i], r);
                chk("data_ack", 32'(r), 0);
                ref_mem[8'(p + 8'(i))] = dat[i];
            end
        end else begin
            chk("busy_nomatch", 32'(busy), 0);
        end
        i2c_stop;
        chk("busy_end", 32'(busy), 0);
        chk("stop_pulses", 32'(stop_cnt - s0), match ? 32'd1 : 32'd0);
        if (!match) chk("sda_driven", 32'(drv_cnt - d0), 0);
        chk("wr_count", 32'(wlog.size() - w0), match ? 32'(n) : 32'd0);
        for (int i = 0; i < n && w0 + i < wlog.size(); i++)
            chk("wr_entry", 32'(wlog[w0 + i]), 32'({8'(p + 8'(i)), dat[i]}));
    endtask

    task automatic rd_txn(input logic [7:0] p, input int n);
        logic r;
        logic [7:0] d;
        int r0 = rlog.size(), s0 = stop_cnt;
        i2c_start;
        byte_tx(8'h78, r);  chk("rd_waddr_ack", 32'(r), 0);
        byte_tx(p, r);      chk("rd_ptr_ack", 32'(r), 0);
        i2c_start;
        byte_tx(8'h79, r);  chk("rd_raddr_ack", 32'(r), 0);
        for (int i = 0; i < n; i++) begin
            byte_rx(i == n - 1, d);
            chk("rd_data", 32'(d), 32'(ref_mem[8'(p + 8'(i))]));
        end
        i2c_stop;
        chk("rd_busy_end", 32'(busy), 0);
        chk("rd_stop_pulses", 32'(stop_cnt - s0), 1);
        chk("rd_count", 32'(rlog.size() - r0), 32'(n));
        for (int i = 0; i < n && r0 + i < rlog.size(); i++)
            chk("rd_addr", 32'(rlog[r0 + i]), 32'(8'(p + 8'(i))));
    endtask

    typedef struct {
        logic [7:0]      addr;
        logic [7:0]      ptr;
        int              n;
        logic [3:0][7:0] dat;
        logic            match;
    } wvec_t;

    wvec_t vt [6];

    initial begin
        logic r;
        logic [7:0] b78, p;
        logic [3:0][7:0] rd;
        int w0, n;

        vt[0] = '{8'h78, 8'h10, 2, {8'h00, 8'h00, 8'h5A, 8'hA5}, 1'b1};
        vt[1] = '{8'h7A, 8'h10, 1, {8'h00, 8'h00, 8'h00, 8'h99}, 1'b0};
        vt[2] = '{8'h78, 8'hFF, 2, {8'h00, 8'h00, 8'h02, 8'h01}, 1'b1};
        vt[3] = '{8'h78, 8'h40, 4, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b1};
        vt[4] = '{8'h76, 8'h00, 0, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b0};
        vt[5] = '{8'h78, 8'h20, 2, {8'h00, 8'h00, 8'hC3, 8'h3C}, 1'b1};

        wait_clk(3);
        chk("rst_sda", 32'(sda), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", 32'(reg_addr), 0);
        chk("rst_wdat", 32'(reg_wdat), 0);
        chk("rst_wr", 32'(reg_wr), 0);
        chk("rst_rd", 32'(reg_rd), 0);
        chk("rst_stop", 32'(stop), 0);
        rst_n = 1'b1;
        wait_clk(5);

        for (int v = 0; v < 6; v++)
            wr_txn(vt[v].addr, vt[v].ptr, vt[v].n, vt[v].dat, vt[v].match);

        rd_txn(8'h20, 2);
        rd_txn(8'hFF, 2);

        // One-cycle SCL spike inside every bit of a data byte.
        i2c_start;
        byte_tx(8'h78, r);
        byte_tx(8'h30, r);
        w0 = wlog.size();
        glitch_en = 1'b1;
        byte_tx(8'h96, r);
        glitch_en = 1'b0;
        chk("glitch_ack", 32'(r), 0);
        i2c_stop;
        chk("glitch_wr_count", 32'(wlog.size() - w0), 1);
        if (wlog.size() > w0) chk("glitch_wr_entry", 32'(wlog[w0]), 32'h3096);
        ref_mem[8'h30] = 8'h96;

        // Reset while the address ACK is on the bus.
        b78 = 8'h78;
        i2c_start;
        for (int i = 7; i >= 0; i--) bit_tx(b78[i], r);
        m_low = 1'b0;
        #1;
        chk("ack_driven", 32'(sda), 0);
        chk("ack_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_sda", 32'(sda), 1);
        chk("rst_mid_busy", 32'(busy), 0);
        wait_clk(2);
        scl = 1'b1;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(Q);
        wr_txn(8'h78, 8'h50, 1, {8'h00, 8'h00, 8'h00, 8'h77}, 1'b1);
        rd_txn(8'h50, 1);

        for (int it = 0; it < 6; it++) begin
            p = 8'($urandom);
            n = $urandom_range(1, 4);
            for (int k = 0; k < 4; k++) rd[k] = 8'($urandom);
            wr_txn(8'h78, p, n, rd, 1'b1);
            rd_txn(p, n);
        end

        chk("protocol_violations", 32'(proto_err), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
